ctrl_teclado_decimal: RTL and testbench

Keypad entry controller for a 10-key decimal keypad. It filters the raw key lines, accepts a digit only when exactly one key is held stable, and converts that key to BCD with the existing 1-of-10 → BCD encoder. It emits one digit per physical press and accumulates up to N_DIGITOS digits in a shift register that feeds the display path.

---
 rtl/ctrl_teclado_decimal_pkg.sv | 14 +
 rtl/cod_decimal_bcd.sv | 18 +
 rtl/ctrl_teclado_decimal.sv | 159 +++++++++++++++
 tb/tb_ctrl_teclado_decimal.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_teclado_decimal_pkg.sv
// Shared constants and state encoding for the decimal keypad controller.
package ctrl_teclado_decimal_pkg;

  localparam int unsigned ANCHO_BCD = 4;
  localparam int unsigned N_TECLAS  = 10;

  typedef enum logic [1:0] {
    REPOSO     = 2'd0,
    FILTRO     = 2'd1,
    PRESIONADA = 2'd2,
    SOLTAR     = 2'd3
  } estado_t;

endpackage

// File: rtl/cod_decimal_bcd.sv
// 1-of-10 to BCD encoder; output is only meaningful for a one-hot input.
module cod_decimal_bcd
  import ctrl_teclado_decimal_pkg::*;
(
  input  logic [N_TECLAS-1:0]  tecla,
  output logic [ANCHO_BCD-1:0] bcd
);

  always_comb begin
    bcd = '0;
    for (int i = 0; i < N_TECLAS; i++) begin
      if (tecla[i]) begin
        bcd = bcd | ANCHO_BCD'(i);
      end
    end
  end

endmodule

// File: rtl/ctrl_teclado_decimal.sv
// Keypad entry controller: debounces press and release, accepts one digit per press
// and shifts accepted digits into a BCD number register.
module ctrl_teclado_decimal
  import ctrl_teclado_decimal_pkg::*;
#(
  parameter int unsigned N_DIGITOS = 4,
  parameter int unsigned DEBOUNCE  = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [N_TECLAS-1:0]            teclas,
  input  logic                           borrar,
  output logic [ANCHO_BCD-1:0]           digito_bcd,
  output logic                           digito_valido,
  output logic [ANCHO_BCD*N_DIGITOS-1:0] numero,
  output logic                           lleno,
  output logic                           error
);

  localparam int unsigned ANCHO_CNT  = $clog2(DEBOUNCE + 1);
  localparam int unsigned ANCHO_CANT = $clog2(N_DIGITOS + 1);
  localparam int unsigned ANCHO_NUM  = ANCHO_BCD * N_DIGITOS;

  localparam logic [ANCHO_CNT-1:0]  CNT_MAX  = ANCHO_CNT'(DEBOUNCE - 1);
  localparam logic [ANCHO_CNT-1:0]  CNT_UNO  = ANCHO_CNT'(1);
  localparam logic [ANCHO_CANT-1:0] CANT_MAX = ANCHO_CANT'(N_DIGITOS);

  estado_t                estado_q, estado_d;
  logic [ANCHO_CNT-1:0]   cnt_q, cnt_d;
  logic [N_TECLAS-1:0]    patron_q, patron_d;
  logic [ANCHO_NUM-1:0]   numero_q, numero_d;
  logic [ANCHO_CANT-1:0]  cantidad_q, cantidad_d;
  logic [ANCHO_BCD-1:0]   digito_q, digito_d;
  logic                   valido_q, lleno_q, lleno_d, error_q, error_d;

  logic                   one_hot, hay_tecla, aceptar;
  logic [ANCHO_BCD-1:0]   bcd_nuevo;

  assign hay_tecla = |teclas;
  assign one_hot   = hay_tecla && ((teclas & (teclas - N_TECLAS'(1))) == '0);

  // Encoder sees the pattern being accepted; with DEBOUNCE=1 that is the live key.
  cod_decimal_bcd u_cod (
    .tecla (patron_d),
    .bcd   (bcd_nuevo)
  );

  always_comb begin
    estado_d = estado_q;
    cnt_d    = cnt_q;
    patron_d = patron_q;
    aceptar  = 1'b0;
    unique case (estado_q)
      REPOSO: begin
        if (one_hot) begin
          patron_d = teclas;
          if (DEBOUNCE == 1) begin
            aceptar  = 1'b1;
            estado_d = PRESIONADA;
          end else begin
            estado_d = FILTRO;
            cnt_d    = CNT_UNO;
          end
        end
      end
      FILTRO: begin
        if (teclas != patron_q) begin
          estado_d = REPOSO;
          cnt_d    = '0;
        end else if (cnt_q == CNT_MAX) begin
          aceptar  = 1'b1;
          estado_d = PRESIONADA;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_UNO;
        end
      end
      PRESIONADA: begin
        if (!hay_tecla) begin
          if (DEBOUNCE == 1) begin
            estado_d = REPOSO;
          end else begin
            estado_d = SOLTAR;
            cnt_d    = CNT_UNO;
          end
        end
      end
      SOLTAR: begin
        if (hay_tecla) begin
          estado_d = PRESIONADA;
          cnt_d    = '0;
        end else if (cnt_q == CNT_MAX) begin
          estado_d = REPOSO;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_UNO;
        end
      end
      default: begin
        estado_d = REPOSO;
        cnt_d    = '0;
      end
    endcase
  end

  // borrar wins over an accept in the same cycle; a full register flags error instead.
  always_comb begin
    numero_d   = numero_q;
    cantidad_d = cantidad_q;
    digito_d   = digito_q;
    error_d    = 1'b0;
    if (aceptar) begin
      digito_d = bcd_nuevo;
    end
    if (borrar) begin
      numero_d   = '0;
      cantidad_d = '0;
    end else if (aceptar) begin
      if (lleno_q) begin
        error_d = 1'b1;
      end else begin
        numero_d   = (numero_q << ANCHO_BCD) | ANCHO_NUM'(bcd_nuevo);
        cantidad_d = cantidad_q + ANCHO_CANT'(1);
      end
    end
    lleno_d = (cantidad_d == CANT_MAX);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado_q   <= REPOSO;
      cnt_q      <= '0;
      patron_q   <= '0;
      numero_q   <= '0;
      cantidad_q <= '0;
      digito_q   <= '0;
      valido_q   <= 1'b0;
      lleno_q    <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      cnt_q      <= cnt_d;
      patron_q   <= patron_d;
      numero_q   <= numero_d;
      cantidad_q <= cantidad_d;
      digito_q   <= digito_d;
      valido_q   <= aceptar;
      lleno_q    <= lleno_d;
      error_q    <= error_d;
    end
  end

  assign digito_bcd    = digito_q;
  assign digito_valido = valido_q;
  assign numero        = numero_q;
  assign lleno         = lleno_q;
  assign error         = error_q;

endmodule

// File: tb/tb_ctrl_teclado_decimal.sv
// Bench for ctrl_teclado_decimal: directed scenarios plus random key activity,
// every cycle compared against a run-length model of the keypad rules.
module tb_ctrl_teclado_decimal;

  localparam int N = 4;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [9:0]   teclas;
  logic         borrar;
  logic [3:0]   digito_bcd;
  logic         digito_valido;
  logic [15:0]  numero;
  logic         lleno;
  logic         error;

  int checks  = 0;
  int errores = 0;
  int n_pulsos = 0;
  int n_err    = 0;

  ctrl_teclado_decimal #(
    .N_DIGITOS (N),
    .DEBOUNCE  (D)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .teclas        (teclas),
    .borrar        (borrar),
    .digito_bcd    (digito_bcd),
    .digito_valido (digito_valido),
    .numero        (numero),
    .lleno         (lleno),
    .error         (error)
  );

  always #5 clk = ~clk;

  // Model: while armed, count consecutive samples of one identical one-hot pattern
  // (a differing sample aborts and is discarded); D of them accept a digit. After an
  // accept, D consecutive all-zero samples re-arm.
  bit         m_armado;
  int         m_run, m_ceros, m_cant;
  logic [9:0] m_pat;
  logic [3:0] m_dig;
  logic [15:0] m_num;
  bit         m_val, m_err, acc;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_armado = 1; m_run = 0; m_ceros = 0; m_cant = 0; m_pat = '0;
      m_dig = '0; m_num = '0; m_val = 0; m_err = 0;
    end else begin
      m_val = 0; m_err = 0; acc = 0;
      if (m_armado) begin
        if (m_run > 0 && teclas == m_pat) m_run++;
        else if (m_run > 0) m_run = 0;
        else if ($countones(teclas) == 1) begin m_pat = teclas; m_run = 1; end
        if (m_run == D) begin acc = 1; m_armado = 0; m_run = 0; m_ceros = 0; end
      end else begin
        if (teclas == 0) m_ceros++; else m_ceros = 0;
        if (m_ceros == D) m_armado = 1;
      end
      if (acc) begin
        m_val = 1;
        for (int i = 0; i < 10; i++) if (m_pat[i]) m_dig = 4'(i);
      end
      if (borrar) begin
        m_num = '0; m_cant = 0;
      end else if (acc) begin
        if (m_cant == N) m_err = 1;
        else begin m_num = 16'((m_num * 16) + m_dig); m_cant++; end
      end
    end
  end

  always @(negedge clk) begin
    checks++;
    if (digito_bcd !== m_dig || digito_valido !== m_val || numero !== m_num ||
        lleno !== (m_cant == N) || error !== m_err) begin
      errores++;
      $display("FAIL model t=%0t: got dig=%0h val=%0b num=%h lleno=%0b err=%0b, expected dig=%0h val=%0b num=%h lleno=%0b err=%0b",
               $time, digito_bcd, digito_valido, numero, lleno, error,
               m_dig, m_val, m_num, (m_cant == N), m_err);
    end
    if (digito_valido === 1'b1) n_pulsos++;
    if (error === 1'b1) n_err++;
  end

  task automatic chk(input string nombre, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errores++;
      $display("FAIL %s: got %0h expected %0h", nombre, act, exp);
    end
  endtask

  task automatic aplicar(input logic [9:0] t, input logic b, input int n);
    teclas = t;
    borrar = b;
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  function automatic logic [9:0] tecla(input int k);
    logic [9:0] v;
    v = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  int p0, e0, r, k, k2;

  initial begin
    reset = 1'b0; teclas = '0; borrar = 1'b0;
    aplicar('0, 0, 3);
    chk("reset_numero", numero, 0);
    chk("reset_digito", digito_bcd, 0);
    chk("reset_flags", {digito_valido, lleno, error}, 0);
    reset = 1'b1;
    aplicar('0, 0, 2);

    // Single press of key 7.
    p0 = n_pulsos;
    aplicar(10'b0010000000, 0, 10);
    aplicar('0, 0, 10);
    chk("t1_pulsos", n_pulsos - p0, 1);
    chk("t1_digito", digito_bcd, 7);
    chk("t1_numero", numero, 16'h0007);
    chk("t1_lleno", lleno, 0);

    // Bounce on key 3, accepted on the 4th sample of the final burst.
    aplicar('0, 1, 1);
    p0 = n_pulsos;
    aplicar(tecla(3), 0, 2);
    aplicar('0, 0, 1);
    aplicar(tecla(3), 0, 3);
    chk("t2_antes", digito_valido, 0);
    aplicar(tecla(3), 0, 1);
    chk("t2_pulso", digito_valido, 1);
    aplicar(tecla(3), 0, 2);
    aplicar('0, 0, 10);
    chk("t2_pulsos", n_pulsos - p0, 1);
    chk("t2_digito", digito_bcd, 3);

    // Multi-hot never accepted.
    p0 = n_pulsos;
    aplicar(10'b0000000110, 0, 20);
    aplicar('0, 0, 5);
    chk("t3_pulsos", n_pulsos - p0, 0);
    chk("t3_numero", numero, 16'h0003);

    // Fill the register, overflow, then clear.
    aplicar('0, 1, 1);
    for (int d = 1; d <= 4; d++) begin
      aplicar(tecla(d), 0, 6);
      aplicar('0, 0, 6);
    end
    chk("t4_numero", numero, 16'h1234);
    chk("t4_lleno", lleno, 1);
    e0 = n_err;
    aplicar(tecla(5), 0, 6);
    aplicar('0, 0, 6);
    chk("t4_error", n_err - e0, 1);
    chk("t4_numero_sin_cambio", numero, 16'h1234);
    aplicar('0, 1, 1);
    aplicar('0, 0, 1);
    chk("t4_borrado", {lleno, numero}, 0);

    // Glitch during release does not produce a second digit.
    p0 = n_pulsos;
    aplicar(tecla(9), 0, 6);
    aplicar('0, 0, 2);
    aplicar(tecla(9), 0, 1);
    aplicar('0, 0, 8);
    chk("t5_pulsos", n_pulsos - p0, 1);
    chk("t5_digito", digito_bcd, 9);

    // Reset during filtering, key held across the release of reset.
    aplicar(tecla(8), 0, 2);
    reset = 1'b0;
    #1;
    chk("t6_reset_inmediato", {digito_bcd, digito_valido, numero, lleno, error}, 0);
    aplicar(tecla(8), 0, 2);
    reset = 1'b1;
    aplicar(tecla(8), 0, 3);
    chk("t6_antes", digito_valido, 0);
    aplicar(tecla(8), 0, 1);
    chk("t6_pulso", digito_valido, 1);
    chk("t6_digito", digito_bcd, 8);
    aplicar('0, 0, 8);
    chk("t6_numero", numero, 16'h0008);

    // Random activity.
    for (int it = 0; it < 300; it++) begin
      r = $urandom_range(0, 9);
      k = $urandom_range(0, 9);
      if (r < 6) begin
        aplicar(tecla(k), ($urandom_range(0, 9) == 0), $urandom_range(1, 7));
        aplicar('0, ($urandom_range(0, 9) == 0), $urandom_range(1, 6));
      end else if (r == 6) begin
        aplicar(10'($urandom), 0, $urandom_range(1, 5));
      end else if (r == 7) begin
        aplicar('0, 1, 1);
      end else if (r == 8) begin
        k2 = $urandom_range(0, 9);
        aplicar(tecla(k), 0, $urandom_range(3, 6));
        aplicar(tecla(k2), 0, $urandom_range(1, 6));
        aplicar('0, 0, $urandom_range(1, 6));
      end else if ($urandom_range(0, 3) == 0) begin
        reset = 1'b0;
        aplicar(teclas, 0, 1);
        reset = 1'b1;
      end else begin
        aplicar('0, 0, $urandom_range(1, 8));
      end
    end
    aplicar('0, 0, 10);

    $display("Result: errors=%0d of %0d checks", errores, checks);
    $finish;
  end

endmodule
